// File: rtl/tamagotchi_stat_display_pkg.sv
// -----------------------------------------------------------------------------
// tamagotchi_stat_display_pkg
// Shared definitions for the pet stat display reader.
//   phase_e      : display phase (status pattern, stat label, stat value)
//   NUM_STATS    : number of 4-bit stats walked per frame
//   SEL_STATUS   : sel_idx code shown while the status pattern is on display
//   GLYPH_*      : label glyphs, one per stat, segment order {g,f,e,d,c,b,a}
//   label_glyph(): stat index -> label glyph
// -----------------------------------------------------------------------------
package tamagotchi_stat_display_pkg;

   typedef enum logic [1:0] {
      SHOW_STATUS = 2'd0,
      SHOW_LABEL  = 2'd1,
      SHOW_VALUE  = 2'd2
   } phase_e;

   localparam int         NUM_STATS  = 6;
   localparam logic [2:0] LAST_IDX   = 3'(NUM_STATS - 1);
   localparam logic [2:0] SEL_STATUS = 3'd7;

   localparam logic [6:0] GLYPH_HUNGER    = 7'h76;  // H
   localparam logic [6:0] GLYPH_HAPPINESS = 7'h73;  // P
   localparam logic [6:0] GLYPH_HEALTH    = 7'h74;  // h
   localparam logic [6:0] GLYPH_HYGIENE   = 7'h6E;  // y
   localparam logic [6:0] GLYPH_ENERGY    = 7'h79;  // E
   localparam logic [6:0] GLYPH_SOCIAL    = 7'h6D;  // S

   function automatic logic [6:0] label_glyph(input logic [2:0] idx);
      logic [6:0] g;
      case (idx)
         3'd0:    g = GLYPH_HUNGER;
         3'd1:    g = GLYPH_HAPPINESS;
         3'd2:    g = GLYPH_HEALTH;
         3'd3:    g = GLYPH_HYGIENE;
         3'd4:    g = GLYPH_ENERGY;
         3'd5:    g = GLYPH_SOCIAL;
         default: g = 7'h00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/tamagotchi_stat_display_hex.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Purely combinational hex digit to 7-segment decoder (active-high segments).
// Ports:
//   hex_i  in  4  nibble to display
//   seg_o  out 7  segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex_to_seg7
   import tamagotchi_stat_display_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = 7'h00;
      case (hex_i)
         4'h0: seg_o = 7'h3F;
         4'h1: seg_o = 7'h06;
         4'h2: seg_o = 7'h5B;
         4'h3: seg_o = 7'h4F;
         4'h4: seg_o = 7'h66;
         4'h5: seg_o = 7'h6D;
         4'h6: seg_o = 7'h7D;
         4'h7: seg_o = 7'h07;
         4'h8: seg_o = 7'h7F;
         4'h9: seg_o = 7'h6F;
         4'hA: seg_o = 7'h77;
         4'hB: seg_o = 7'h7C;
         4'hC: seg_o = 7'h39;
         4'hD: seg_o = 7'h5E;
         4'hE: seg_o = 7'h79;
         4'hF: seg_o = 7'h71;
         default: seg_o = 7'h00;
      endcase
   end

endmodule

// File: rtl/tamagotchi_stat_display.sv
// -----------------------------------------------------------------------------
// tamagotchi_stat_display
// Round-robin reader that shows the pet status pattern, then for each of the
// six stats a label glyph followed by the stat's hex value, each phase held
// for DWELL cycles. A push button can force an early advance.
//
// Optional feature macro: BLINK_LOW_EN -- when defined, stat values below 4
// blank during the second half of their value phase.
//
// Ports:
//   clk_i         in   1  clock, rising edge
//   rst_ni        in   1  synchronous active-low reset
//   enable_i      in   1  dwell counter runs when high
//   btn_next_i    in   1  asynchronous manual-advance button
//   status_i      in   7  raw status segment pattern
//   hunger_i .. social_i  in 4 each  stat values (index 0..5)
//   seg_out_o     out  7  segments {g,f,e,d,c,b,a}
//   dp_out_o      out  1  decimal point, high in label phases
//   sel_idx_o     out  3  stat index shown, 7 during status phase
//   frame_done_o  out  1  pulse on the first status cycle of each new frame
// -----------------------------------------------------------------------------
module tamagotchi_stat_display
   import tamagotchi_stat_display_pkg::*;
#(
   parameter int unsigned DWELL = 24'd10_000_000
)
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       enable_i,
   input  logic       btn_next_i,
   input  logic [6:0] status_i,
   input  logic [3:0] hunger_i,
   input  logic [3:0] happiness_i,
   input  logic [3:0] health_i,
   input  logic [3:0] hygiene_i,
   input  logic [3:0] energy_i,
   input  logic [3:0] social_i,
   output logic [6:0] seg_out_o,
   output logic       dp_out_o,
   output logic [2:0] sel_idx_o,
   output logic       frame_done_o
);

   localparam logic [23:0] CNT_LAST = 24'(DWELL - 1);
`ifdef BLINK_LOW_EN
   localparam logic [23:0] CNT_HALF = 24'(DWELL >> 1);
`endif

   phase_e      state_q;
   logic [2:0]  idx_q;
   logic [23:0] cnt_q;
   logic        btn_meta_q;
   logic        btn_sync_q;
   logic        btn_prev_q;
   logic        btn_edge_q;
   logic        wrap_q;
   logic [3:0]  value_q;

   logic        advance;
   logic [3:0]  stat_sel;
   logic [6:0]  value_seg;
   logic        value_blank;
   logic [6:0]  seg_d;
   logic        dp_d;
   logic [2:0]  sel_d;

   always_comb begin
      stat_sel = 4'h0;
      case (idx_q)
         3'd0:    stat_sel = hunger_i;
         3'd1:    stat_sel = happiness_i;
         3'd2:    stat_sel = health_i;
         3'd3:    stat_sel = hygiene_i;
         3'd4:    stat_sel = energy_i;
         3'd5:    stat_sel = social_i;
         default: stat_sel = 4'h0;
      endcase
   end

   hex_to_seg7 u_hex (
      .hex_i (value_q),
      .seg_o (value_seg)
   );

   // A button edge and a dwell expiry in the same cycle still yield one step.
   assign advance = (enable_i && (cnt_q == CNT_LAST)) || btn_edge_q;

`ifdef BLINK_LOW_EN
   assign value_blank = (value_q < 4'd4) && (cnt_q >= CNT_HALF);
`else
   assign value_blank = 1'b0;
`endif

   always_comb begin
      seg_d = status_i;
      dp_d  = 1'b0;
      sel_d = SEL_STATUS;
      case (state_q)
         SHOW_LABEL: begin
            seg_d = label_glyph(idx_q);
            dp_d  = 1'b1;
            sel_d = idx_q;
         end
         SHOW_VALUE: begin
            seg_d = value_blank ? 7'h00 : value_seg;
            sel_d = idx_q;
         end
         default: ;
      endcase
   end

   // Stat value is captured on the label->value transition so it stays steady
   // for the whole value phase even if the stat keeps changing.
   always_ff @(posedge clk_i) begin
      if (advance && (state_q == SHOW_LABEL)) begin
         value_q <= stat_sel;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= SHOW_STATUS;
         idx_q        <= 3'd0;
         cnt_q        <= 24'd0;
         btn_meta_q   <= 1'b0;
         btn_sync_q   <= 1'b0;
         btn_prev_q   <= 1'b0;
         btn_edge_q   <= 1'b0;
         wrap_q       <= 1'b0;
         seg_out_o    <= 7'h00;
         dp_out_o     <= 1'b0;
         sel_idx_o    <= SEL_STATUS;
         frame_done_o <= 1'b0;
      end else begin
         // Two-flop synchronizer followed by a registered rising-edge pulse.
         btn_meta_q <= btn_next_i;
         btn_sync_q <= btn_meta_q;
         btn_prev_q <= btn_sync_q;
         btn_edge_q <= btn_sync_q & ~btn_prev_q;

         seg_out_o    <= seg_d;
         dp_out_o     <= dp_d;
         sel_idx_o    <= sel_d;
         frame_done_o <= wrap_q;

         // wrap_q marks the first cycle in status after a completed frame.
         wrap_q <= 1'b0;

         if (advance) begin
            cnt_q <= 24'd0;
            case (state_q)
               SHOW_STATUS: begin
                  state_q <= SHOW_LABEL;
                  idx_q   <= 3'd0;
               end
               SHOW_LABEL: begin
                  state_q <= SHOW_VALUE;
               end
               SHOW_VALUE: begin
                  if (idx_q == LAST_IDX) begin
                     state_q <= SHOW_STATUS;
                     idx_q   <= 3'd0;
                     wrap_q  <= 1'b1;
                  end else begin
                     state_q <= SHOW_LABEL;
                     idx_q   <= idx_q + 3'd1;
                  end
               end
               default: begin
                  state_q <= SHOW_STATUS;
                  idx_q   <= 3'd0;
               end
            endcase
         end else if (enable_i) begin
            cnt_q <= cnt_q + 24'd1;
         end
      end
   end

endmodule

// File: tb/tb_tamagotchi_stat_display.sv
// -----------------------------------------------------------------------------
// tb_tamagotchi_stat_display
// Randomized scoreboard bench for tamagotchi_stat_display (DWELL=4).
// The reference model tracks the frame as a phase number 0..12
// (0 = status, odd = label k, even = value k) and predicts the registered
// outputs for every clock edge. Honors BLINK_LOW_EN when defined.
// -----------------------------------------------------------------------------
module tb_tamagotchi_stat_display;

   localparam int DWELL = 4;

   typedef struct packed {
      logic [6:0] seg;
      logic       dp;
      logic [2:0] sel;
      logic       fd;
   } out_t;

   localparam logic [6:0] HEX_TAB [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71 };
   localparam logic [6:0] LBL_TAB [6] = '{
      7'h76, 7'h73, 7'h74, 7'h6E, 7'h79, 7'h6D };

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       btn;
   logic [6:0] status;
   logic [3:0] st [6];
   logic [6:0] seg;
   logic       dp;
   logic [2:0] sel;
   logic       fd;

   always #5 clk = ~clk;

   tamagotchi_stat_display #(.DWELL(DWELL)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .enable_i     (enable),
      .btn_next_i   (btn),
      .status_i     (status),
      .hunger_i     (st[0]),
      .happiness_i  (st[1]),
      .health_i     (st[2]),
      .hygiene_i    (st[3]),
      .energy_i     (st[4]),
      .social_i     (st[5]),
      .seg_out_o    (seg),
      .dp_out_o     (dp),
      .sel_idx_o    (sel),
      .frame_done_o (fd)
   );

   out_t expq [$];
   int   checks   = 0;
   int   failures = 0;
   bit   done     = 0;

   // reference model state
   int         m_phase = 0;
   int         m_cnt   = 0;
   logic [3:0] m_latch = 4'h0;
   bit         m_wrap  = 0;
   bit [3:0]   m_hist  = 4'b0;  // m_hist[k] = button level sampled k+1 edges ago

   // Apply inputs for the next rising edge, predict the output registered at
   // that edge, advance the model, then wait for the following falling edge.
   task automatic cycle(input bit r, input bit e, input bit b);
      out_t x;
      bit   adv;
      rst_n  = r;
      enable = e;
      btn    = b;
      if (!r) begin
         x = '{7'h00, 1'b0, 3'd7, 1'b0};
      end else begin
         x.fd = m_wrap;
         if (m_phase == 0) begin
            x.seg = status; x.dp = 1'b0; x.sel = 3'd7;
         end else if (m_phase % 2 == 1) begin
            x.seg = LBL_TAB[(m_phase - 1) / 2]; x.dp = 1'b1; x.sel = 3'((m_phase - 1) / 2);
         end else begin
            x.seg = HEX_TAB[m_latch]; x.dp = 1'b0; x.sel = 3'((m_phase - 2) / 2);
`ifdef BLINK_LOW_EN
            if (m_latch < 4 && m_cnt >= DWELL / 2) x.seg = 7'h00;
`endif
         end
      end
      expq.push_back(x);

      if (!r) begin
         m_phase = 0; m_cnt = 0; m_wrap = 0; m_hist = 4'b0;
      end else begin
         // button rising edge reaches the phase logic three edges after sampling
         adv    = (e && m_cnt == DWELL - 1) || (m_hist[2] && !m_hist[3]);
         m_wrap = 0;
         if (adv) begin
            if (m_phase % 2 == 1) m_latch = st[(m_phase - 1) / 2];
            m_wrap  = (m_phase == 12);
            m_phase = (m_phase + 1) % 13;
            m_cnt   = 0;
         end else if (e) begin
            m_cnt++;
         end
         m_hist = {m_hist[2:0], b};
      end
      @(negedge clk);
   endtask

   // Run enabled until the model reaches the given phase/count, bounded.
   task automatic run_to(input int ph, input int cn);
      int n;
      n = 0;
      while (!(m_phase == ph && m_cnt == cn) && n < 200) begin
         cycle(1, 1, 0);
         n++;
      end
      checks++;
      if (n >= 200) begin
         failures++;
         $display("FAIL run_to phase=%0d cnt=%0d not reached, at phase=%0d", ph, cn, m_phase);
      end
   endtask

   // monitor: compare each registered output against the queued prediction
   initial begin
      out_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            a = '{seg, dp, sel, fd};
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL out t=%0t seg=%h dp=%b sel=%0d fd=%b expected seg=%h dp=%b sel=%0d fd=%b",
                        $time, a.seg, a.dp, a.sel, a.fd, e.seg, e.dp, e.sel, e.fd);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      int btn_left;
      bit btn_lvl;
      bit r, e;

      rst_n = 1'b0; enable = 1'b1; btn = 1'b0; status = 7'h55;
      st[0] = 4'h3; st[1] = 4'h5; st[2] = 4'hA;
      st[3] = 4'hC; st[4] = 4'h2; st[5] = 4'hF;

      repeat (3) cycle(0, 1, 0);

      // two full frames, hunger changed mid value phase of stat 0
      for (int i = 0; i < 110; i++) begin
         if (i == 10) st[0] = 4'h9;
         cycle(1, 1, 0);
      end

      // freeze in the middle of label for stat 2
      run_to(5, 1);
      repeat (10) cycle(1, 0, 0);
      repeat (12) cycle(1, 1, 0);

      // button pulse of 5 cycles while frozen in status
      run_to(0, 1);
      repeat (5) cycle(1, 0, 1);
      repeat (10) cycle(1, 0, 0);

      // button edges at every offset relative to dwell expiry
      for (int off = 0; off < 8; off++) begin
         repeat (off) cycle(1, 1, 0);
         repeat (2) cycle(1, 1, 1);
         repeat (9) cycle(1, 1, 0);
      end

      // reset pulse during value phase of stat 4
      run_to(10, 2);
      cycle(0, 1, 0);
      repeat (60) cycle(1, 1, 0);

      // randomized traffic
      btn_left = 0;
      btn_lvl  = 0;
      for (int i = 0; i < 4000; i++) begin
         if (btn_left == 0) begin
            btn_lvl  = ($urandom_range(0, 3) == 0);
            btn_left = $urandom_range(1, 12);
         end
         btn_left--;
         status = 7'($urandom);
         if ($urandom_range(0, 5) == 0) st[$urandom_range(0, 5)] = 4'($urandom);
         r = ($urandom_range(0, 399) != 0);
         e = ($urandom_range(0, 7) != 0);
         cycle(r, e, btn_lvl);
      end

      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (expq.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d expected=0", expq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tamagotchi_stat_display.md
# tamagotchi_stat_display

Display-side reader for the pet's stat registers and status pattern. Walks round-robin through the 7-bit status pattern and the six 4-bit stats: a label glyph for each stat, then its hex value, each held for a programmable dwell time. Drives the 7-segment output and a decimal point, so one display can show all the pet state that the stats and states logic write each cycle.

## Interface
- DWELL, 24'd10_000_000, cycles each phase is held; legal range 2..2^24-1
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  high = dwell counter runs; low = freeze counter, FSM and outputs
- btn_next  in  1  asynchronous push-button, manual advance
- status  in  7  raw segment pattern from the states logic
- hunger, happiness, health, hygiene, energy, social  in  4 each  stat values
- seg_out  out  7  segments {g,f,e,d,c,b,a}, active-high
- dp_out  out  1  decimal point, high during label phases
- sel_idx  out  3  stat index being shown (0=hunger … 5=social), 7 during status phase
- frame_done  out  1  one-cycle pulse at start of each new frame

## Operation
- FSM states: SHOW_STATUS, SHOW_LABEL, SHOW_VALUE. Index register idx is 0..5.
- Sequence: SHOW_STATUS → (LABEL idx0 → VALUE idx0) … (LABEL idx5 → VALUE idx5) → SHOW_STATUS. One frame is 13 phases.
- Phase advance happens when either condition holds:
  - dwell counter == DWELL-1 with enable high, or
  - a btn_next rising edge is detected.
- On advance the counter clears to 0.
- A dwell expiry and a button edge in the same cycle cause exactly one advance.
- btn_next path: 2-flop synchronizer, then an edge detector (sync current high, previous low).
- Button edges act even when enable is low.
- SHOW_STATUS: seg_out = status, tracked live every cycle. dp_out=0, sel_idx=7.
- SHOW_LABEL: seg_out = glyph[idx], dp_out=1, sel_idx=idx. Glyphs:
  - H 7'h76, P 7'h73, h 7'h74
  - y 7'h6E, E 7'h79, S 7'h6D
- SHOW_VALUE: the selected stat is latched on the transition edge into the phase. seg_out = hex glyph of the latched value, held constant for the phase. dp_out=0.
- Hex glyphs: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- frame_done: asserted in the cycle seg_out first shows status after VALUE idx5. Never asserted on the first frame after reset.
- Reset values:
  - FSM = SHOW_STATUS, idx=0, counter=0, sync flops=0
  - seg_out=0, dp_out=0, sel_idx=7, frame_done=0
- Reset mid-frame discards the position. Display restarts at SHOW_STATUS.

## Timing
- All outputs registered. Each output reflects the FSM state/idx with 1-cycle latency; in SHOW_STATUS, seg_out lags status by 1 cycle.
- Each phase lasts exactly DWELL cycles with enable held high. Frame period = 13·DWELL cycles.
- Button-to-advance latency: 3 cycles (2 sync + edge register). Outputs change 1 cycle after that.
- While enable is low, the counter holds its value, and resumes from the held value when enable rises.

## Configuration
- BLINK_LOW_EN defined: in SHOW_VALUE with latched value < 4, seg_out = 0 while counter ≥ DWELL>>1. The value shows in the first half of the phase and is blank in the second half.
- BLINK_LOW_EN undefined: value glyph is steady for the whole phase. No blink comparator is synthesized.

## Structure
- Shared package:
  - phase enum (SHOW_STATUS/SHOW_LABEL/SHOW_VALUE)
  - NUM_STATS=6, SEL_STATUS=3'd7
  - the six label glyph constants
- Sub-module: hex_to_seg7. Purely combinational, 4-bit in to 7-bit out, same segment order. Reused by other display logic.

## Test plan
- DWELL=4, enable=1, status=7'h55, hunger=3 after reset:
  - seg_out=55 for 4 cycles, then 76 with dp_out=1 for 4, then 4F for 4.
  - frame_done pulses every 52 cycles.
- Latching: hunger changes 3→9 in the middle of VALUE idx0 → seg_out stays 4F until the phase ends. The next frame shows 6F.
- enable=0 for 10 cycles mid-LABEL idx2 → seg_out=74 and sel_idx=2 hold. The remaining dwell completes after enable returns.
- btn_next pulse of 5 cycles during SHOW_STATUS with DWELL=1000 → exactly one advance, to LABEL idx0, 4 cycles after the rising edge.
- btn edge arriving on the same cycle as dwell expiry → single advance. sel_idx skips no stat.
- rst_n low for 1 cycle during VALUE idx4 → next cycle all outputs at reset values, then restart at SHOW_STATUS.
- BLINK_LOW_EN, energy=2, DWELL=4 → VALUE idx4 shows 5B for 2 cycles, 00 for 2. Without the macro, 5B for 4.
